// File: rtl/hi_lo_multiply_divide_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// One shift-add or restoring-divide step per cycle, sign fix-up, then commit.
//
//  state   | meaning
//  IDLE    | waiting for start_execute; MTHI/MTLO accepted
//  MUL_RUN | one shift-add step per cycle on magnitudes
//  DIV_RUN | one restoring-divide step per cycle on magnitudes
//  FIXUP   | sign correction and HI/LO commit, done pulses
module hi_lo_multiply_divide_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_execute,
  input  logic [1:0]       op_execute,
  input  logic [WIDTH-1:0] operand_a_execute,
  input  logic [WIDTH-1:0] operand_b_execute,
  input  logic             mthi_execute,
  input  logic             mtlo_execute,
  input  logic             hilo_use_decode,
  output logic             busy,
  output logic             done,
  output logic             hilo_stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] upper_q, lower_q, opnd_q;
  logic             neg_q, rneg_q, is_div_q;

  logic             op_signed, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    op_signed = ~op_execute[0];
    a_neg     = op_signed & operand_a_execute[WIDTH-1];
    b_neg     = op_signed & operand_b_execute[WIDTH-1];
    a_mag     = a_neg ? -operand_a_execute : operand_a_execute;
    b_mag     = b_neg ? -operand_b_execute : operand_b_execute;
    div_zero  = op_execute[1] && (operand_b_execute == '0);
  end

  // Multiply: accumulate into the upper half, shift the {upper,lower} pair right.
  always_comb begin
    mul_sum = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : '0);
  end

  // Restoring divide: remainder in upper, dividend shifts out of lower as quotient shifts in.
  always_comb begin
    div_shift = {upper_q, lower_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
  end

  always_comb begin
    prod_raw = {upper_q, lower_q};
    prod_fix = neg_q  ? -prod_raw : prod_raw;
    quot_fix = neg_q  ? -lower_q  : lower_q;
    rem_fix  = rneg_q ? -upper_q  : upper_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_execute) begin
          if (div_zero)           state_d = FIXUP;
          else if (op_execute[1]) state_d = DIV_RUN;
          else                    state_d = MUL_RUN;
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (count_q == '0) state_d = FIXUP;
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      upper_q  <= '0;
      lower_q  <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_execute) begin
            count_q  <= CW'(WIDTH - 1);
            is_div_q <= op_execute[1];
            if (div_zero) begin
              // Fix-up passes these straight through: LO all ones, HI = dividend.
              upper_q <= operand_a_execute;
              lower_q <= '1;
              opnd_q  <= '0;
              neg_q   <= 1'b0;
              rneg_q  <= 1'b0;
            end else if (op_execute[1]) begin
              upper_q <= '0;
              lower_q <= a_mag;
              opnd_q  <= b_mag;
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
            end else begin
              upper_q <= '0;
              lower_q <= b_mag;
              opnd_q  <= a_mag;
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= 1'b0;
            end
          end else begin
            if (mthi_execute) hi_out <= operand_a_execute;
            if (mtlo_execute) lo_out <= operand_a_execute;
          end
        end
        MUL_RUN: begin
          upper_q <= mul_sum[WIDTH:1];
          lower_q <= {mul_sum[0], lower_q[WIDTH-1:1]};
          if (count_q != '0) count_q <= count_q - 1'b1;
        end
        DIV_RUN: begin
          if (!div_trial[WIDTH+1]) begin
            upper_q <= div_trial[WIDTH-1:0];
            lower_q <= {lower_q[WIDTH-2:0], 1'b1};
          end else begin
            upper_q <= div_shift[WIDTH-1:0];
            lower_q <= {lower_q[WIDTH-2:0], 1'b0};
          end
          if (count_q != '0) count_q <= count_q - 1'b1;
        end
        FIXUP: begin
          if (is_div_q) begin
            hi_out <= rem_fix;
            lo_out <= quot_fix;
          end else begin
            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
            lo_out <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIXUP);
  assign hilo_stall = busy & hilo_use_decode;

endmodule

// File: tb/tb_hi_lo_multiply_divide_sequencer.sv
// Self-checking bench: directed and random mul/div ops against an arithmetic model.
module tb_hi_lo_multiply_divide_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_execute;
  logic [1:0]   op_execute;
  logic [W-1:0] operand_a_execute, operand_b_execute;
  logic         mthi_execute, mtlo_execute, hilo_use_decode;
  logic         busy, done, hilo_stall;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  hi_lo_multiply_divide_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_execute(start_execute), .op_execute(op_execute),
    .operand_a_execute(operand_a_execute), .operand_b_execute(operand_b_execute),
    .mthi_execute(mthi_execute), .mtlo_execute(mtlo_execute),
    .hilo_use_decode(hilo_use_decode), .busy(busy), .done(done),
    .hilo_stall(hilo_stall), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Architectural results computed with plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    int sa, sb, q, r;
    longint p;
    logic [63:0] u;
    sa = a; sb = b;
    h = '0; l = '0;
    case (op)
      2'b00: begin p = longint'(sa) * longint'(sb); {h, l} = p; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; {h, l} = u; end
      default: begin
        if (b == 0) begin
          l = '1; h = a;
        end else if (op == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000; h = '0;
          end else begin
            q = sa / sb; r = sa % sb; l = q; h = r;
          end
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  // Issues one op and follows it to completion. use_at/restart_at/move_at are
  // observation indices (0 = first cycle after the start edge), -1 disables.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int use_at, input int restart_at,
                        input int move_at, input bit move_with_start);
    logic [W-1:0] eh, el, h0, l0;
    int last, busy_n, done_n, errs, k;
    bit use_now, finished, busy_exp, done_exp;
    model(op, a, b, eh, el);
    h0 = hi_out; l0 = lo_out;
    last = (op[1] && b == 0) ? 0 : W;
    busy_n = 0; done_n = 0; errs = 0; use_now = 0; finished = 0;
    start_execute = 1'b1; op_execute = op; operand_a_execute = a; operand_b_execute = b;
    mthi_execute = move_with_start; mtlo_execute = move_with_start;
    tick();
    start_execute = 1'b0; mthi_execute = 1'b0; mtlo_execute = 1'b0;
    if (use_at == 0) begin use_now = 1; hilo_use_decode = 1'b1; end
    for (k = 0; k < 100; k++) begin
      if (k == last + 1) begin finished = 1; break; end
      busy_exp = (k <= last);
      done_exp = (k == last);
      if (busy !== busy_exp || done !== done_exp || hilo_stall !== (busy_exp && use_now)) errs++;
      if (hi_out !== h0 || lo_out !== l0) errs++;
      if (busy) busy_n++;
      if (done) done_n++;
      if (k + 1 == use_at) begin use_now = 1; hilo_use_decode = 1'b1; end
      if (k + 1 == restart_at) begin
        start_execute = 1'b1; op_execute = 2'($urandom);
        operand_a_execute = $urandom; operand_b_execute = $urandom;
      end else start_execute = 1'b0;
      if (k + 1 == move_at) begin
        mthi_execute = 1'b1; mtlo_execute = 1'b1; operand_a_execute = $urandom;
      end else begin
        mthi_execute = 1'b0; mtlo_execute = 1'b0;
      end
      tick();
    end
    chk({tag, "_finished"}, 64'(finished), 64'd1);
    chk({tag, "_timing"}, 64'(errs), 64'd0);
    chk({tag, "_idle_stall"}, {62'b0, busy, hilo_stall}, 64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(last + 1));
    chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, "_hilo"}, {hi_out, lo_out}, {eh, el});
    hilo_use_decode = 1'b0;
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start_execute = 1'b0; op_execute = '0;
    operand_a_execute = '0; operand_b_execute = '0;
    mthi_execute = 1'b0; mtlo_execute = 1'b0; hilo_use_decode = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(hilo_stall), 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0; hilo_use_decode = 1'b0;
    tick();

    run_op("mult_m2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, -1, -1, -1, 0);
    chk("mult_m2x3_exact", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1, 0);
    chk("multu_max_exact", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, -1, 0);
    chk("div_m7_2_exact", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7_0", 2'b11, 32'd7, 32'd0, -1, -1, -1, 0);
    chk("divu_7_0_exact", {hi_out, lo_out}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 0);
    run_op("div_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, -1, -1, -1, 0);
    run_op("div_stall", 2'b10, 32'd1000, 32'hFFFF_FFFD, 5, 9, -1, 0);
    run_op("mult_mthi", 2'b00, 32'h1234_5678, 32'h8000_0000, -1, -1, 7, 0);
    run_op("divu_movedrop", 2'b11, 32'hDEAD_BEEF, 32'd17, -1, -1, -1, 1);

    operand_a_execute = 32'h1234; mtlo_execute = 1'b1;
    tick();
    mtlo_execute = 1'b0;
    chk("mtlo_idle", 64'(lo_out), 64'h1234);
    operand_a_execute = 32'hCAFE_0001; mthi_execute = 1'b1;
    tick();
    mthi_execute = 1'b0;
    chk("mthi_idle", {hi_out, lo_out}, 64'hCAFE_0001_0000_1234);

    start_execute = 1'b1; op_execute = 2'b00;
    operand_a_execute = 32'h0001_0003; operand_b_execute = 32'h0000_0005;
    tick();
    start_execute = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", {61'b0, busy, done, hilo_stall}, 64'd0);
    chk("abort_hilo", {hi_out, lo_out}, 64'd0);
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, -1, -1, -1, 0);
    chk("multu_6x7_exact", {hi_out, lo_out}, 64'd42);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op($sformatf("rand%0d", i), rop, ra, rb, int'($urandom_range(0, 40)) - 8, -1, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
